// File: rtl/cell_pos_streamer.sv
`default_nettype none
// ============================================================================
// Module      : cell_pos_streamer
// Description : Read-side sequencer for one per-cell position memory.
//               On start, reads the particle count from address 0, then streams
//               every particle record (addresses 1..N) to the force pipeline
//               over a valid/ready interface. A small first-word-fall-through
//               FIFO with credit-limited read issue absorbs the 2-cycle memory
//               read latency under backpressure.
// Ports       : clock, rst_n          - clock / async active-low reset
//               start, busy, done     - control handshake
//               particle_count        - clamped count read from address 0
//               mem_*                 - single-port cell memory (read only)
//               out_data/id/last      - particle beat payload
//               out_valid, out_ready  - downstream valid/ready handshake
// Revision    : 1.0 - initial release
// ============================================================================
module cell_pos_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W     = $clog2(FIFO_DEPTH + 3) + 1;
    localparam int MAX_COUNT = PARTICLE_NUM - 1;
    // The count is compared over the whole posx field so that values wider
    // than the address (e.g. 300) clamp instead of wrapping.
    localparam int COUNT_W   = (DATA_WIDTH < 32) ? DATA_WIDTH : 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CNT_RD   = 3'd1,
        S_CNT_WAIT = 3'd2,
        S_STREAM   = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t                 state;
    logic                   wait_second;
    logic [ADDR_WIDTH-1:0]  next_addr;

    // Read pipeline tags, aligned with mem_q at stage 2.
    logic                   s1_valid, s2_valid;
    logic [ADDR_WIDTH-1:0]  s1_id, s2_id;
    logic                   s1_last, s2_last;

    // Output FIFO.
    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_id   [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]       fifo_wr_ptr, fifo_rd_ptr;
    logic [CNT_W-1:0]       fifo_count;

    logic                   push, pop, issue, credit_ok;
    logic [CRD_W-1:0]       credit_used;
    logic [COUNT_W-1:0]     raw_count;
    logic [ADDR_WIDTH-1:0]  clamped_count;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_data[fifo_rd_ptr];
    assign out_id    = fifo_id[fifo_rd_ptr];
    assign out_last  = fifo_last[fifo_rd_ptr];

    assign pop  = out_valid && out_ready;
    assign push = s2_valid;

    // Every word already buffered or still in the read pipeline holds a slot.
    // A pop this cycle frees its slot immediately, so the check subtracts it.
    assign credit_used = CRD_W'(fifo_count) + CRD_W'(s1_valid) + CRD_W'(s2_valid)
                         - CRD_W'(pop);
    assign credit_ok   = (credit_used < CRD_W'(FIFO_DEPTH));
    assign issue       = (state == S_STREAM) && credit_ok;

    assign mem_rden    = (state == S_CNT_RD) || issue;
    assign mem_address = issue ? next_addr : '0;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;

    assign raw_count     = mem_q[COUNT_W-1:0];
    assign clamped_count = (raw_count > COUNT_W'(MAX_COUNT)) ? ADDR_WIDTH'(MAX_COUNT)
                                                             : raw_count[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            wait_second    <= 1'b0;
            next_addr      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            particle_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is ignored.
                    if (start && !done) begin
                        state <= S_CNT_RD;
                        busy  <= 1'b1;
                    end
                end
                S_CNT_RD: begin
                    state       <= S_CNT_WAIT;
                    wait_second <= 1'b0;
                end
                S_CNT_WAIT: begin
                    if (!wait_second) begin
                        wait_second <= 1'b1;
                    end else begin
                        particle_count <= clamped_count;
                        if (clamped_count == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            next_addr <= ADDR_WIDTH'(1);
                            state     <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        next_addr <= next_addr + 1'b1;
                        if (next_addr == particle_count) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last && !s1_valid && !s2_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read tag pipeline and output FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            s1_last     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_id       <= '0;
            s2_last     <= 1'b0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            s1_valid <= issue;
            s1_id    <= next_addr;
            s1_last  <= (next_addr == particle_count);
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_last  <= s1_last;

            if (push) begin
                fifo_data[fifo_wr_ptr] <= mem_q;
                fifo_id[fifo_wr_ptr]   <= s2_id;
                fifo_last[fifo_wr_ptr] <= s2_last;
                fifo_wr_ptr <= (fifo_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0
                                                                       : fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= (fifo_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0
                                                                       : fifo_rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_pos_streamer
// Description : Self-checking bench for cell_pos_streamer. A behavioural
//               2-cycle-latency cell memory feeds the DUT; expected beats are
//               queued when a stream is started and compared as they are
//               accepted downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_pos_streamer;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    typedef struct {
        logic [AW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clock;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_id;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    cell_pos_streamer #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .particle_count(particle_count),
        .mem_address   (mem_address),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_data      (mem_data),
        .mem_q         (mem_q),
        .out_data      (out_data),
        .out_id        (out_id),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cell memory model: address sampled on the rden edge, data visible two
    // cycles after the rden/address cycle.
    logic [DW-1:0] cell_mem [PN];
    logic [DW-1:0] mq_p1;
    always @(posedge clock) begin
        if (mem_rden) mq_p1 <= cell_mem[mem_address];
        mem_q <= mq_p1;
    end

    int    cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    start_edge = 0;
    int    done_exp = -1;
    int    done_cnt = 0;
    int    rd_cnt = 0;
    int    beat_cnt = 0;
    bit    first_pending = 0;

    logic          prev_valid = 0;
    logic          prev_ready = 0;
    logic [AW-1:0] prev_id;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Output monitor / scoreboard, sampled on the falling edge
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (mem_rden) begin
                rd_cnt++;
                check("mem_no_write", {mem_wren, mem_data}, '0);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_hold", {out_valid, out_last, out_id, out_data},
                      {1'b1, prev_last, prev_id, prev_data});
            end
            if (first_pending && out_valid) begin
                first_pending = 0;
                check("first_valid_latency", cyc - start_edge, 6);
            end
            if (out_valid && out_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {out_id, out_data}, '0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_payload", {out_last, out_id, out_data}, {e.last, e.id, e.data});
                    if (e.last) done_exp = cyc + 1;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, done_exp);
                check("busy_low_at_done", busy, 0);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_id    = out_id;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic load_cell(input int count_word);
        cell_mem[0] = DW'(count_word);
        for (int i = 1; i < PN; i++) begin
            cell_mem[i] = {$urandom(), 32'(i * 1000 + 7), $urandom()};
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Pulses start for one cycle and queues the expected beats.
    task automatic do_start(input int n_eff);
        tick(1);
        start      = 1'b1;
        start_edge = cyc + 1;
        rd_cnt     = 0;
        done_exp   = -1;
        first_pending = (n_eff > 0);
        for (int i = 1; i <= n_eff; i++) begin
            beat_t b;
            b.id   = AW'(i);
            b.data = cell_mem[i];
            b.last = (i == n_eff);
            exp_q.push_back(b);
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, (done_cnt >= target), 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int dones;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        load_cell(5);
        tick(3);
        check("reset_outputs",
              {busy, done, out_valid, mem_rden, mem_wren, particle_count, mem_address, out_id},
              '0);
        check("reset_out_data", out_data, '0);
        rst_n = 1'b1;
        tick(2);
        dones = 0;

        // Five-particle stream at full throughput.
        load_cell(5);
        do_start(5);
        dones++;
        wait_done(dones, "done_5");
        check("count_5", particle_count, 5);
        check("queue_empty_5", exp_q.size(), 0);
        tick(3);

        // Empty cell, plus a start coinciding with the done pulse.
        load_cell(0);
        do_start(0);
        done_exp = start_edge + 3;
        while (cyc < start_edge + 3) tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        dones++;
        wait_done(dones, "done_empty");
        tick(4);
        check("count_empty", particle_count, 0);
        check("start_at_done_ignored", {busy, 8'(done_cnt)}, {1'b0, 8'(dones)});
        check("empty_no_reads", rd_cnt, 1);

        // Oversized count clamps to PARTICLE_NUM-1.
        load_cell(300);
        do_start(PN - 1);
        dones++;
        wait_done(dones, "done_clamp");
        check("count_clamp", particle_count, PN - 1);
        check("queue_empty_clamp", exp_q.size(), 0);
        tick(3);

        // Backpressure: four outstanding words, then toggled ready.
        load_cell(10);
        out_ready = 1'b0;
        do_start(10);
        tick(20);
        check("stall_read_credit", rd_cnt, 5);
        check("stall_head", {out_valid, out_id}, {1'b1, 8'd1});
        for (int i = 0; i < 200 && done_cnt < dones + 1; i++) begin
            out_ready = ~out_ready;
            tick(1);
        end
        out_ready = 1'b1;
        dones++;
        wait_done(dones, "done_backpressure");
        check("queue_empty_bp", exp_q.size(), 0);
        tick(3);

        // Start while busy is ignored; start one cycle after done is taken.
        load_cell(4);
        do_start(4);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        dones++;
        wait_done(dones, "done_busy_start");
        do_start(4);
        dones++;
        wait_done(dones, "done_restart");
        tick(5);
        check("done_count_restart", done_cnt, dones);
        check("queue_empty_restart", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stream.
        load_cell(10);
        do_start(10);
        while (cyc < start_edge + 5) tick(1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {busy, done, out_valid, mem_rden, particle_count, out_id}, '0);
        exp_q.delete();
        first_pending = 0;
        done_exp = -1;
        tick(3);
        rst_n = 1'b1;
        beat_cnt = 0;
        tick(12);
        check("no_stale_beats", {busy, out_valid, 8'(beat_cnt)}, '0);
        do_start(10);
        dones++;
        wait_done(dones, "done_after_reset");
        check("beats_after_reset", beat_cnt, 10);
        check("queue_empty_reset", exp_q.size(), 0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
